rf_nr1w_clr: RTL and testbench

//  Parametrised N-read/1-write CPU register file for the ID stage; successor of the fixed 2r1w RF.

---
 rtl/rf_nr1w_clr_pkg.sv | 27 ++
 rtl/rf_nr1w_clr_if.sv | 40 ++++
 rtl/rf_nr1w_clr_rd_port.sv | 55 +++++
 rtl/rf_nr1w_clr.sv | 127 ++++++++++++
 tb/tb_rf_nr1w_clr.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_nr1w_clr_pkg.sv
// ---------------------------------------------------------------------------
// Package rf_pkg
// Shared definitions for the N-read/1-write register file rf_nr1w_clr:
//   - clear-sequencer FSM state encoding
//   - default geometry (data width, depth, read-port count)
//   - rf_clog2: elaboration-time ceil(log2(n)) used to size address fields
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int RF_DW_DEF    = 32;
  localparam int RF_DEPTH_DEF = 32;
  localparam int RF_NRD_DEF   = 2;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // ceil(log2(n)), with a floor of 1 so a 1-entry array still has an address bit.
  function automatic int rf_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rf_nr1w_clr_if.sv
// ---------------------------------------------------------------------------
// Interface rf_nr1w_clr_if
// Bundles the operand-read, write-back and clear-control signals of the
// register file.
//   ram_radr   NRD*AW  read addresses, port p at [p*AW +: AW]
//   ram_rdata  NRD*DW  registered read data, port p at [p*DW +: DW]
//   ram_wadr   AW      write address
//   ram_wdata  DW      write data
//   ram_wen    1       write enable
//   clr_req    1       clear request pulse
//   clr_busy   1       clear sequence running
// Modports: master = ID/WB side (drives addresses/data), slave = register file.
// ---------------------------------------------------------------------------
interface rf_nr1w_clr_if
  import rf_pkg::*;
#(
  parameter int DW  = RF_DW_DEF,
  parameter int AW  = rf_clog2(RF_DEPTH_DEF),
  parameter int NRD = RF_NRD_DEF
);

  logic [NRD*AW-1:0] ram_radr;
  logic [NRD*DW-1:0] ram_rdata;
  logic [AW-1:0]     ram_wadr;
  logic [DW-1:0]     ram_wdata;
  logic              ram_wen;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output ram_radr, ram_wadr, ram_wdata, ram_wen, clr_req,
    input  ram_rdata, clr_busy
  );

  modport slave (
    input  ram_radr, ram_wadr, ram_wdata, ram_wen, clr_req,
    output ram_rdata, clr_busy
  );

endinterface

// File: rtl/rf_nr1w_clr_rd_port.sv
// ---------------------------------------------------------------------------
// Module rf_rd_port
// One registered read port of the register file.
//   clk, rst    clock / asynchronous active-high reset
//   radr        read address sampled at the rising edge
//   mem_rdata   combinational array contents at radr
//   rd_zero     force the port to 0 (clear sequence in progress or starting)
//   wr_acc      write accepted this edge        (RF_BYPASS_EN only)
//   wadr, wdata address / data of that write    (RF_BYPASS_EN only)
//   rdata       registered read data, 1-cycle latency
// Optional feature macro: RF_BYPASS_EN -- write-first forwarding of a write
// to the same address on the same edge. Undefined: read-first, no
// forwarding hardware.
// ---------------------------------------------------------------------------
module rf_rd_port
  import rf_pkg::*;
#(
  parameter int DW       = RF_DW_DEF,
  parameter int AW       = rf_clog2(RF_DEPTH_DEF),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] radr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          rd_zero,
`ifdef RF_BYPASS_EN
  input  logic          wr_acc,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdata,
`endif
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] rdata_d;

  // NOTE: every always_comb output gets a default on its first line, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rdata_d = mem_rdata;
`ifdef RF_BYPASS_EN
    if (wr_acc && (wadr == radr)) rdata_d = wdata;
`endif
    // Zero-forcing wins over forwarding: entry 0 and the clear window read 0.
    if (rd_zero || (ZERO_REG && (radr == '0))) rdata_d = '0;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= rdata_d;
  end

endmodule

// File: rtl/rf_nr1w_clr.sv
// ---------------------------------------------------------------------------
// Module rf_nr1w_clr
// Parametrised N-read/1-write register file for the ID stage, written from
// WB. Registered synchronous reads, optional hardwired-zero entry 0, and a
// clear sequencer that zeroes every entry after reset (the array maps to
// block RAM, which has no reset) or on clr_req.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous reset, active-high
//   bus   rf_nr1w_clr_if.slave (read/write ports, clr_req, clr_busy)
// Parameters: DW, DEPTH (power of 2), AW = clog2(DEPTH), NRD (1..4), ZERO_REG.
// Optional feature macro: RF_BYPASS_EN (write-first forwarding on the read
// ports; see rf_rd_port).
// ---------------------------------------------------------------------------
module rf_nr1w_clr
  import rf_pkg::*;
#(
  parameter int DW       = RF_DW_DEF,
  parameter int DEPTH    = RF_DEPTH_DEF,
  parameter int AW       = rf_clog2(DEPTH),
  parameter int NRD      = RF_NRD_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  rf_nr1w_clr_if.slave    bus
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q;
  logic          wr_acc;
  logic          rd_zero;
  logic          last_entry;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data [NRD];

  // -------------------------------------------------------------------------
  // Clear sequencer
  // -------------------------------------------------------------------------
  assign last_entry = (cnt_q == AW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_CLEAR: begin
        // DEPTH is a power of two, so the increment out of DEPTH-1 lands on
        // 0 exactly at the transition to IDLE; the counter never free-runs.
        cnt_d = cnt_q + AW'(1);
        if (last_entry) state_d = RF_IDLE;
      end
      RF_IDLE: begin
        if (bus.clr_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Registered from the next state so busy tracks the FSM edge-for-edge.
      busy_q  <= (state_d == RF_CLEAR);
    end
  end

  assign bus.clr_busy = busy_q;

  // -------------------------------------------------------------------------
  // Write arbitration: the sequencer owns the write port during CLEAR and the
  // WB write is dropped; entry 0 is read-only when hardwired to zero.
  // -------------------------------------------------------------------------
  assign wr_acc = (state_q == RF_IDLE) && bus.ram_wen &&
                  !(ZERO_REG && (bus.ram_wadr == '0));

  // NOTE: the array has no reset branch -- block RAM cannot be reset; the
  // clear sequencer provides defined contents instead.
  always_ff @(posedge clk) begin
    if (state_q == RF_CLEAR) mem[cnt_q]        <= '0;
    else if (wr_acc)         mem[bus.ram_wadr] <= bus.ram_wdata;
  end

  // Reads return 0 for the whole clear window, including the edge that starts
  // a clear, so no stale pre-clear data is ever presented while busy.
  assign rd_zero = (state_q == RF_CLEAR) || (state_d == RF_CLEAR);

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] radr;
    assign radr = bus.ram_radr[p*AW +: AW];

    rf_rd_port #(
      .DW       (DW),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .clk       (clk),
      .rst       (rst),
      .radr      (radr),
      .mem_rdata (mem[radr]),
      .rd_zero   (rd_zero),
`ifdef RF_BYPASS_EN
      .wr_acc    (wr_acc),
      .wadr      (bus.ram_wadr),
      .wdata     (bus.ram_wdata),
`endif
      .rdata     (rd_data[p])
    );
  end

  always_comb begin
    bus.ram_rdata = '0;
    for (int p = 0; p < NRD; p++) bus.ram_rdata[p*DW +: DW] = rd_data[p];
  end

endmodule

// File: tb/tb_rf_nr1w_clr.sv
// ---------------------------------------------------------------------------
// Testbench for rf_nr1w_clr. Reference model: an array of entry values plus
// a "clear in progress / cycles remaining" pair, updated once per clock from
// the architectural rules of the register file.
// ---------------------------------------------------------------------------
module tb_rf_nr1w_clr;

  localparam int DW       = 32;
  localparam int DEPTH    = 32;
  localparam int AW       = 5;
  localparam int NRD      = 2;
  localparam bit ZERO_REG = 1'b1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rf_nr1w_clr_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

  rf_nr1w_clr #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_busy;
  int            m_left;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_rd(input int p, input logic [AW-1:0] a);
    bus.ram_radr[p*AW +: AW] = a;
  endtask

  task automatic set_rd_all(input logic [AW-1:0] a);
    for (int p = 0; p < NRD; p++) bus.ram_radr[p*AW +: AW] = a;
  endtask

  task automatic idle_inputs();
    bus.ram_wen   = 1'b0;
    bus.clr_req   = 1'b0;
    bus.ram_wadr  = '0;
    bus.ram_wdata = '0;
  endtask

  task automatic model_reset();
    m_busy = 1'b1;
    m_left = DEPTH;
    // Contents after the post-reset clear are all zero; reads before then are forced to 0.
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // One clock: predict outputs from current inputs, advance the model, clock
  // the DUT, then compare busy and every read port.
  task automatic step(input string tag);
    logic [DW-1:0] exp_rd [NRD];
    logic [AW-1:0] a;
    bit            start_clr;
    bit            wr_ok;
    start_clr = !m_busy && bus.clr_req;
    wr_ok     = !m_busy && bus.ram_wen && !(ZERO_REG && bus.ram_wadr == 0);
    for (int p = 0; p < NRD; p++) begin
      a = bus.ram_radr[p*AW +: AW];
      if (m_busy || start_clr)       exp_rd[p] = '0;
      else if (ZERO_REG && a == 0)   exp_rd[p] = '0;
`ifdef RF_BYPASS_EN
      else if (wr_ok && bus.ram_wadr == a) exp_rd[p] = bus.ram_wdata;
`endif
      else                           exp_rd[p] = ref_mem[a];
    end
    if (m_busy) begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end else begin
      if (wr_ok) ref_mem[bus.ram_wadr] = bus.ram_wdata;
      if (start_clr) begin
        m_busy = 1'b1;
        m_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.clr_busy !== m_busy)
      $display("FAIL %s clr_busy: got %b expected %b", tag, bus.clr_busy, m_busy);
    else
      n_pass++;
    for (int p = 0; p < NRD; p++) begin
      n_checks++;
      if (bus.ram_rdata[p*DW +: DW] !== exp_rd[p])
        $display("FAIL %s rdata[%0d]: got %h expected %h", tag, p,
                 bus.ram_rdata[p*DW +: DW], exp_rd[p]);
      else
        n_pass++;
    end
  endtask

  // Step until clr_busy falls; report the number of clock edges taken.
  task automatic count_busy(input string tag, input int expected);
    int n;
    n = 0;
    do begin
      step(tag);
      n++;
    end while (bus.clr_busy === 1'b1 && n < 200);
    n_checks++;
    if (n !== expected)
      $display("FAIL %s busy_cycles: got %0d expected %0d", tag, n, expected);
    else
      n_pass++;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      set_rd_all(AW'(i));
      step(tag);
      n_checks++;
      if (bus.ram_rdata !== '0)
        $display("FAIL %s addr %0d: got %h expected 0", tag, i, bus.ram_rdata);
      else
        n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    set_rd_all('0);
    model_reset();
    #1;
    n_checks++;
    if (bus.clr_busy !== 1'b1 || bus.ram_rdata !== '0)
      $display("FAIL reset_values: got busy=%b rdata=%h expected busy=1 rdata=0",
               bus.clr_busy, bus.ram_rdata);
    else
      n_pass++;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    count_busy("post_reset_clear", DEPTH);
    read_all_zero("post_reset_read");
  endtask

  task automatic test_write_read();
    bus.ram_wen = 1'b1; bus.ram_wadr = 5'd5; bus.ram_wdata = 32'hDEADBEEF;
    set_rd_all(5'd9);
    step("wr_x5");
    bus.ram_wen = 1'b0;
    set_rd_all(5'd5);
    step("rd_x5");
    n_checks++;
    if (bus.ram_rdata[0 +: DW] !== 32'hDEADBEEF || bus.ram_rdata[DW +: DW] !== 32'hDEADBEEF)
      $display("FAIL both_ports_x5: got %h expected deadbeef on both", bus.ram_rdata);
    else
      n_pass++;
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] exp;
    exp = ZERO_REG ? '0 : 32'h12345678;
    bus.ram_wen = 1'b1; bus.ram_wadr = '0; bus.ram_wdata = 32'h12345678;
    step("wr_x0");
    bus.ram_wen = 1'b0;
    set_rd_all('0);
    step("rd_x0");
    n_checks++;
    if (bus.ram_rdata[0 +: DW] !== exp)
      $display("FAIL zero_reg_x0: got %h expected %h", bus.ram_rdata[0 +: DW], exp);
    else
      n_pass++;
  endtask

  task automatic test_rd_during_wr();
    logic [DW-1:0] exp;
`ifdef RF_BYPASS_EN
    exp = 32'h22;
`else
    exp = 32'h11;
`endif
    bus.ram_wen = 1'b1; bus.ram_wadr = 5'd7; bus.ram_wdata = 32'h11;
    step("wr_x7_old");
    bus.ram_wdata = 32'h22;
    set_rd_all(5'd7);
    step("rdw_x7");
    bus.ram_wen = 1'b0;
    n_checks++;
    if (bus.ram_rdata[DW +: DW] !== exp)
      $display("FAIL rd_during_wr_x7: got %h expected %h", bus.ram_rdata[DW +: DW], exp);
    else
      n_pass++;
    step("rd_x7_new");
    n_checks++;
    if (bus.ram_rdata[0 +: DW] !== 32'h22)
      $display("FAIL x7_after_write: got %h expected 00000022", bus.ram_rdata[0 +: DW]);
    else
      n_pass++;
  endtask

  task automatic test_clear();
    for (int i = 1; i < DEPTH; i++) begin
      bus.ram_wen = 1'b1; bus.ram_wadr = AW'(i); bus.ram_wdata = 32'hA5000000 | i;
      set_rd(0, AW'(i - 1)); set_rd(1, AW'(i));
      step("fill");
    end
    bus.ram_wen = 1'b0;
    bus.clr_req = 1'b1;
    step("clr_start");
    bus.clr_req = 1'b0;
    // Writes and a repeated clr_req inside the window must both be ignored.
    bus.ram_wen = 1'b1; bus.ram_wadr = 5'd3; bus.ram_wdata = 32'hFFFF0000;
    step("clr_wr_dropped");
    bus.ram_wen = 1'b0;
    bus.clr_req = 1'b1;
    step("clr_req_ignored");
    bus.clr_req = 1'b0;
    count_busy("clr_rest", DEPTH - 2);
    read_all_zero("after_clr");
  endtask

  task automatic test_reset_mid_clear();
    // Asynchronous reset during normal operation with nonzero read data.
    bus.ram_wen = 1'b1; bus.ram_wadr = 5'd12; bus.ram_wdata = 32'hCAFE0012;
    step("wr_x12");
    bus.ram_wen = 1'b0;
    set_rd_all(5'd12);
    step("rd_x12");
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.clr_busy !== 1'b1 || bus.ram_rdata !== '0)
      $display("FAIL async_reset_idle: got busy=%b rdata=%h expected busy=1 rdata=0",
               bus.clr_busy, bus.ram_rdata);
    else
      n_pass++;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy("clear_after_idle_reset", DEPTH);
    // Reset at clear count 10.
    bus.clr_req = 1'b1;
    step("clr_start2");
    bus.clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step("clr_to_10");
    #2;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.clr_busy !== 1'b1 || bus.ram_rdata !== '0)
        $display("FAIL busy_in_reset: got busy=%b rdata=%h expected busy=1 rdata=0",
                 bus.clr_busy, bus.ram_rdata);
      else
        n_pass++;
    end
    rst = 1'b0;
    count_busy("clear_after_mid_reset", DEPTH);
    read_all_zero("after_mid_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.ram_wen   = 1'($urandom_range(0, 1));
      bus.ram_wadr  = AW'($urandom_range(0, DEPTH - 1));
      bus.ram_wdata = $urandom;
      bus.clr_req   = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NRD; p++)
        set_rd(p, ($urandom_range(0, 3) == 0) ? bus.ram_wadr : AW'($urandom_range(0, DEPTH - 1)));
      step("random");
    end
    idle_inputs();
    // Let any clear started by the random traffic finish before moving on.
    for (int i = 0; i < DEPTH + 2 && m_busy; i++) step("random_drain");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_rd_during_wr();
    test_clear();
    test_random();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
